// File: rtl/out_display.sv
// out_display: SAP-1 output register with a sequential binary-to-BCD converter
// (shift-add-3) and a time-multiplexed 4-position 7-segment display driver.
// Optional feature macro: OUT_DISPLAY_SIGNED_EN (two's complement display with
// a "-" on the sign position). Default build is unsigned 0..255.
module out_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus,
    input  logic       out_ld,
    output logic [7:0] out_val,
    output logic       busy,
    output logic [3:0] dig_en,
    output logic [6:0] seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [7:0]      out_val_r;
    logic            busy_r;
    logic [7:0]      shift_r, shift_next_s;
    logic [9:0]      bcd_r, bcd_next_s;
    logic [2:0]      step_r;
    logic [3:0]      hund_r, tens_r, units_r;
    logic [CW-1:0]   scan_cnt_r;
    logic [3:0]      dig_en_r;
    logic [7:0]      mag_s;
    logic [6:0]      seg_s;
    logic [17:0]     dabble_s;
`ifdef OUT_DISPLAY_SIGNED_EN
    logic            neg_pend_r;
    logic            neg_r;
`endif

    // Add-3 correction applied to a BCD nibble before it is shifted.
    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // 7-segment pattern {g,f,e,d,c,b,a} for a decimal digit; anything else blanks.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Value fed to the converter: raw byte, or its magnitude when signed (8'h80 -> 128).
    always_comb begin
        mag_s = bus;
`ifdef OUT_DISPLAY_SIGNED_EN
        if (bus[7]) begin
            mag_s = 8'd0 - bus;
        end else begin
            mag_s = bus;
        end
`endif
    end

    // One double-dabble step: adjust tens/units nibbles, then shift {bcd,shift} left.
    // The hundreds field only ever reaches 2, so it never needs adjusting.
    always_comb begin
        dabble_s     = {bcd_r[9:8], add3(bcd_r[7:4]), add3(bcd_r[3:0]), shift_r};
        bcd_next_s   = dabble_s[16:7];
        shift_next_s = {dabble_s[6:0], 1'b0};
    end

    // Next-state logic; a load restarts the conversion from any state.
    always_comb begin
        state_next_s = state_r;
        if (out_ld) begin
            state_next_s = CONV;
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                CONV:    state_next_s = (step_r == 3'd7) ? DONE : CONV;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture, conversion datapath and commit of the displayed digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_r <= 8'd0;
            busy_r    <= 1'b0;
            shift_r   <= 8'd0;
            bcd_r     <= 10'd0;
            step_r    <= 3'd0;
            hund_r    <= 4'd0;
            tens_r    <= 4'd0;
            units_r   <= 4'd0;
        end else if (out_ld) begin
            out_val_r <= bus;
            busy_r    <= 1'b1;
            shift_r   <= mag_s;
            bcd_r     <= 10'd0;
            step_r    <= 3'd0;
        end else if (state_r == CONV) begin
            shift_r   <= shift_next_s;
            bcd_r     <= bcd_next_s;
            step_r    <= step_r + 3'd1;
        end else if (state_r == DONE) begin
            hund_r    <= {2'b00, bcd_r[9:8]};
            tens_r    <= bcd_r[7:4];
            units_r   <= bcd_r[3:0];
            busy_r    <= 1'b0;
        end else begin
            busy_r    <= busy_r;
        end
    end

`ifdef OUT_DISPLAY_SIGNED_EN
    // Sign of the pending conversion, committed together with the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_pend_r <= 1'b0;
            neg_r      <= 1'b0;
        end else if (out_ld) begin
            neg_pend_r <= bus[7];
        end else if (state_r == DONE) begin
            neg_r      <= neg_pend_r;
        end else begin
            neg_r      <= neg_r;
        end
    end
`endif

    // Free-running digit scan: rotate the one-hot enable each SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            dig_en_r   <= 4'b0001;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            dig_en_r   <= {dig_en_r[2:0], dig_en_r[3]};
        end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
        end
    end

    // Segment pattern for the enabled position, with leading-zero blanking.
    always_comb begin
        seg_s = 7'h00;
        case (dig_en_r)
            4'b0001: seg_s = seg_code(units_r);
            4'b0010: begin
                if ((hund_r == 4'd0) && (tens_r == 4'd0)) begin
                    seg_s = 7'h00;
                end else begin
                    seg_s = seg_code(tens_r);
                end
            end
            4'b0100: begin
                if (hund_r == 4'd0) begin
                    seg_s = 7'h00;
                end else begin
                    seg_s = seg_code(hund_r);
                end
            end
            4'b1000: begin
`ifdef OUT_DISPLAY_SIGNED_EN
                if (neg_r) begin
                    seg_s = 7'h40;
                end else begin
                    seg_s = 7'h00;
                end
`else
                seg_s = 7'h00;
`endif
            end
            default: seg_s = 7'h00;
        endcase
    end

    assign out_val = out_val_r;
    assign busy    = busy_r;
    assign dig_en  = dig_en_r;
    assign seg     = seg_s;

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display (SCAN_DIV=2 so every position is visited quickly).
module tb_out_display;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus;
    logic       out_ld;
    logic [7:0] out_val;
    logic       busy;
    logic [3:0] dig_en;
    logic [6:0] seg;

    int vectors;
    int miscompares;

    out_display #(.SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .out_ld(out_ld),
        .out_val(out_val), .busy(busy), .dig_en(dig_en), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse out_ld for one edge; returns at the negedge after the load edge.
    task automatic do_load(input logic [7:0] v);
        bus    = v;
        out_ld = 1'b1;
        @(negedge clk);
        out_ld = 1'b0;
    endtask

    // Count cycles busy stays high (bounded).
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for a display position and return its segments.
    task automatic read_pos(input int pos, output logic [6:0] v, output bit found);
        found = 1'b0;
        v     = 7'h00;
        for (int i = 0; i < 20; i++) begin
            if (dig_en == (4'b0001 << pos)) begin
                found = 1'b1;
                v     = seg;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; bus = 8'd0; out_ld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_val !== 8'd0 || busy !== 1'b0 || dig_en !== 4'b0001 || seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL reset_state: out_val=%0d busy=%b dig_en=%b seg=%h, want 0 0 0001 3f",
                     out_val, busy, dig_en, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan;
        logic [3:0] exp [9];
        exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (dig_en !== exp[i]) begin
                miscompares++;
                $display("FAIL scan_%0d: dig_en=%b want %b", i, dig_en, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    // Load a value, check capture and busy length, then check all four positions.
    task automatic load_and_show(input logic [7:0] v, input logic [6:0] e_u, input logic [6:0] e_t,
                                 input logic [6:0] e_h, input logic [6:0] e_s);
        int cnt;
        logic [6:0] s;
        bit f;
        logic [6:0] exp [4];
        exp = '{e_u, e_t, e_h, e_s};
        do_load(v);
        vectors++;
        if (out_val !== v || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL capture_%0d: out_val=%0d busy=%b want %0d 1", v, out_val, busy, v);
        end
        wait_busy(cnt);
        vectors++;
        if (cnt != 9) begin
            miscompares++;
            $display("FAIL busy_len_%0d: %0d cycles want 9", v, cnt);
        end
        for (int p = 0; p < 4; p++) begin
            read_pos(p, s, f);
            vectors++;
            if (!f || s !== exp[p]) begin
                miscompares++;
                $display("FAIL digit_%0d_pos%0d: seg=%h found=%b want %h", v, p, s, f, exp[p]);
            end
        end
    endtask

    task automatic test_unsigned;
`ifndef OUT_DISPLAY_SIGNED_EN
        load_and_show(8'd237, 7'h07, 7'h4F, 7'h5B, 7'h00);
        load_and_show(8'd255, 7'h6D, 7'h6D, 7'h5B, 7'h00);
`endif
        load_and_show(8'd105, 7'h6D, 7'h3F, 7'h06, 7'h00);
        load_and_show(8'd0,   7'h3F, 7'h00, 7'h00, 7'h00);
        load_and_show(8'd5,   7'h6D, 7'h00, 7'h00, 7'h00);
    endtask

    task automatic test_signed;
`ifdef OUT_DISPLAY_SIGNED_EN
        load_and_show(8'hF6, 7'h3F, 7'h06, 7'h00, 7'h40);
        load_and_show(8'h80, 7'h7F, 7'h5B, 7'h06, 7'h40);
        load_and_show(8'h7F, 7'h07, 7'h5B, 7'h06, 7'h00);
        load_and_show(8'h05, 7'h6D, 7'h00, 7'h00, 7'h00);
`endif
    endtask

    // Load 200, reload 9 while busy: hundreds must never light, busy 9 after reload.
    task automatic test_back_to_back;
        int cnt;
        logic [6:0] s;
        bit f;
        do_load(8'd200);
        for (int i = 0; i < 3; i++) begin
            if (dig_en == 4'b0100) begin
                vectors++;
                if (seg !== 7'h00) begin
                    miscompares++;
                    $display("FAIL restart_hund_early: seg=%h want 00", seg);
                end
            end
            @(negedge clk);
        end
        do_load(8'd9);
        vectors++;
        if (out_val !== 8'd9) begin
            miscompares++;
            $display("FAIL restart_out_val: %0d want 9", out_val);
        end
        cnt = 0;
        while (busy && cnt < 40) begin
            if (dig_en == 4'b0100) begin
                vectors++;
                if (seg !== 7'h00) begin
                    miscompares++;
                    $display("FAIL restart_hund: seg=%h want 00", seg);
                end
            end
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt != 9) begin
            miscompares++;
            $display("FAIL restart_busy_len: %0d want 9", cnt);
        end
        read_pos(0, s, f);
        vectors++;
        if (!f || s !== 7'h6F) begin
            miscompares++;
            $display("FAIL restart_units: seg=%h want 6f", s);
        end
        read_pos(2, s, f);
        vectors++;
        if (!f || s !== 7'h00) begin
            miscompares++;
            $display("FAIL restart_hund_final: seg=%h want 00", s);
        end
    endtask

    // Asynchronous reset in the middle of a conversion and of the scan.
    task automatic test_reset_midconv;
        do_load(8'd123);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_val !== 8'd123 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: out_val=%0d busy=%b want 123 1", out_val, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_val !== 8'd0 || busy !== 1'b0 || dig_en !== 4'b0001 || seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL midconv_reset: out_val=%0d busy=%b dig_en=%b seg=%h want 0 0 0001 3f",
                     out_val, busy, dig_en, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_val !== 8'd0) begin
            miscompares++;
            $display("FAIL aborted_conv: busy=%b out_val=%0d want 0 0", busy, out_val);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scan();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_midconv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
